// File: rtl/hamming_tx_serializer.sv
// -----------------------------------------------------------------------------
// hamming_tx_serializer
//
// Transmit stage for the Hamming(7,4) link. A 4-bit nibble is taken over a
// valid/ready handshake and encoded into a 7-bit codeword with even or odd
// parity. The codeword is then shifted out LSB first, one bit per cycle, with
// start/end-of-frame strobes. An optional run of idle cycles follows each
// codeword before another word can be accepted.
//
// Codeword layout x[6:0] = {d3, d2, d1, p4, d0, p2, p1}. This is bit-compatible
// with the team's Hamming(7,4) decoder.
//
// Parameters
//   GAP_CYCLES  idle cycles after each codeword (0..15). With 0, a new word
//               can be accepted during the last bit, so words go out back to
//               back with no bubble.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   select      parity polarity, 0 = even, 1 = odd (sampled at acceptance)
//   in_valid    in_data is valid
//   in_data     data nibble d[3:0]
//   in_ready    a word can be accepted this cycle
//   tx_bit      serial codeword bit
//   tx_valid    tx_bit is valid
//   tx_sof      high with bit 0 of each codeword
//   tx_eof      high with bit 6 of each codeword
//   cw_out      most recently accepted codeword
//   word_count  completed codewords, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module hamming_tx_serializer #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    output logic        in_ready,
    output logic        tx_bit,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic [6:0]  cw_out,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Last value of the gap counter before returning to IDLE. Only meaningful
    // when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [6:0]  sr_reg, sr_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [3:0]  gap_cnt_reg, gap_cnt_next;
    logic [6:0]  cw_reg, cw_next;
    logic [15:0] word_count_reg, word_count_next;

    logic [6:0]  cw_new;

    // Odd parity inverts every parity bit so each syndrome group XORs to 1.
    always_comb begin
        cw_new    = '0;
        cw_new[2] = in_data[0];
        cw_new[4] = in_data[1];
        cw_new[5] = in_data[2];
        cw_new[6] = in_data[3];
        cw_new[0] = in_data[0] ^ in_data[1] ^ in_data[3] ^ select;
        cw_new[1] = in_data[0] ^ in_data[2] ^ in_data[3] ^ select;
        cw_new[3] = in_data[1] ^ in_data[2] ^ in_data[3] ^ select;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sr_reg         <= '0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            cw_reg         <= '0;
            word_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            bit_cnt_reg    <= bit_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            cw_reg         <= cw_next;
            word_count_reg <= word_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sr_next         = sr_reg;
        bit_cnt_next    = bit_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        cw_next         = cw_reg;
        word_count_next = word_count_reg;
        in_ready        = 1'b0;
        tx_valid        = 1'b0;
        tx_bit          = 1'b0;
        tx_sof          = 1'b0;
        tx_eof          = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_next      = cw_new;
                    cw_next      = cw_new;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end

            SHIFT: begin
                tx_valid     = 1'b1;
                tx_bit       = sr_reg[0];
                tx_sof       = (bit_cnt_reg == 3'd0);
                tx_eof       = (bit_cnt_reg == 3'd6);
                sr_next      = {1'b0, sr_reg[6:1]};
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd6) begin
                    word_count_next = word_count_reg + 16'd1;
                    bit_cnt_next    = '0;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_next = '0;
                        state_next   = GAP;
                    end else begin
                        // Accepting during the eof cycle keeps the line busy
                        // with no idle bubble between codewords.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            sr_next    = cw_new;
                            cw_next    = cw_new;
                            state_next = SHIFT;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end

            GAP: begin
                gap_cnt_next = gap_cnt_reg + 4'd1;
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cw_out     = cw_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
module tb_hamming_tx_serializer;

    typedef struct {
        logic       b;
        logic       sof;
        logic       eof;
    } exp_bit_t;

    typedef struct {
        logic       sel;
        logic [3:0] d;
        logic [6:0] cw;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        select;
    logic [3:0]  in_data;
    logic        iv0, iv2;
    logic        rdy0, rdy2;
    logic        bit0, bit2, val0, val2, sof0, sof2, eof0, eof2;
    logic [6:0]  cw0, cw2;
    logic [15:0] wc0, wc2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int run0  = 0;
    int maxrun0 = 0;
    exp_bit_t q0[$];
    exp_bit_t q2[$];
    int sofc2[$];

    always #5 clk = ~clk;

    hamming_tx_serializer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .select(select), .in_valid(iv0), .in_data(in_data),
        .in_ready(rdy0), .tx_bit(bit0), .tx_valid(val0), .tx_sof(sof0),
        .tx_eof(eof0), .cw_out(cw0), .word_count(wc0)
    );

    hamming_tx_serializer #(.GAP_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .select(select), .in_valid(iv2), .in_data(in_data),
        .in_ready(rdy2), .tx_bit(bit2), .tx_valid(val2), .tx_sof(sof2),
        .tx_eof(eof2), .cw_out(cw2), .word_count(wc2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d, input logic sel);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3] ^ sel;
        p2 = d[0] ^ d[2] ^ d[3] ^ sel;
        p4 = d[1] ^ d[2] ^ d[3] ^ sel;
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Output monitors: compare every valid serial bit against the scoreboard.
    always @(negedge clk) begin
        exp_bit_t e;
        cyc++;
        if (val0) begin
            run0++;
            if (run0 > maxrun0) maxrun0 = run0;
            if (q0.size() == 0) begin
                chk("dut0_unexpected_bit", 32'(val0), 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0_bit", {29'd0, bit0, sof0, eof0}, {29'd0, e.b, e.sof, e.eof});
            end
        end else begin
            run0 = 0;
            chk("dut0_idle_outputs", {29'd0, bit0, sof0, eof0}, 32'd0);
        end
        chk("dut0_ready", 32'(rdy0), 32'(!val0 || eof0));

        if (val2) begin
            if (sof2) sofc2.push_back(cyc);
            if (q2.size() == 0) begin
                chk("dut2_unexpected_bit", 32'(val2), 32'd0);
            end else begin
                e = q2.pop_front();
                chk("dut2_bit", {29'd0, bit2, sof2, eof2}, {29'd0, e.b, e.sof, e.eof});
            end
        end else begin
            chk("dut2_idle_outputs", {29'd0, bit2, sof2, eof2}, 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present a word and wait for the handshake; expected bits are queued at
    // the accepting cycle. in_valid is left high for the caller to manage.
    task automatic send(input int which, input logic [3:0] d, input logic sel, input logic [6:0] cw);
        bit done = 0;
        in_data = d;
        select  = sel;
        if (which == 0) iv0 = 1'b1; else iv2 = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            if ((which == 0) ? rdy0 : rdy2) begin
                for (int i = 0; i < 7; i++) begin
                    if (which == 0) q0.push_back('{cw[i], i == 0, i == 6});
                    else            q2.push_back('{cw[i], i == 0, i == 6});
                end
                done = 1;
            end
            tick();
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        else chk("first_bit_latency", (which == 0) ? {30'd0, val0, sof0} : {30'd0, val2, sof2}, 32'd3);
    endtask

    task automatic wait_idle(input int which);
        bit done = 0;
        for (int t = 0; t < 60 && !done; t++) begin
            if (which == 0) done = (q0.size() == 0) && !val0 && rdy0;
            else            done = (q2.size() == 0) && !val2 && rdy2;
            if (!done) tick();
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs[6];
    logic [15:0] wc_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 4'b1011, 7'b1010101};
        vecs[1] = '{1'b1, 4'b1011, 7'b1011110};
        vecs[2] = '{1'b1, 4'b0000, 7'b0001011};
        vecs[3] = '{1'b0, 4'b1111, 7'b1111111};
        vecs[4] = '{1'b0, 4'b0001, 7'b0000111};
        vecs[5] = '{1'b1, 4'b0110, 7'b0111000};

        rst = 1'b1; iv0 = 1'b0; iv2 = 1'b0; select = 1'b0; in_data = 4'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_ready0", 32'(rdy0), 32'd1);
        chk("reset_ready2", 32'(rdy2), 32'd1);
        chk("reset_txvalid", {30'd0, val0, val2}, 32'd0);
        chk("reset_cw", {18'd0, cw0, cw2}, 32'd0);
        chk("reset_count", {wc0, wc2}, 32'd0);

        // Table-driven single words.
        for (int v = 0; v < 6; v++) begin
            wc_before = wc0;
            send(0, vecs[v].d, vecs[v].sel, vecs[v].cw);
            iv0 = 1'b0;
            wait_idle(0);
            chk("table_cw", 32'(cw0), 32'(vecs[v].cw));
            chk("table_count", 32'(wc0), 32'(wc_before + 16'd1));
            $display("vector %0d: sel=%0b d=%b cw=%b count=%0d", v, vecs[v].sel, vecs[v].d, cw0, wc0);
        end

        // Back-to-back with in_valid held high.
        wc_before = wc0;
        maxrun0 = 0;
        send(0, 4'h3, 1'b0, enc(4'h3, 1'b0));
        send(0, 4'hC, 1'b0, enc(4'hC, 1'b0));
        send(0, 4'h5, 1'b0, enc(4'h5, 1'b0));
        iv0 = 1'b0;
        wait_idle(0);
        chk("b2b_run_length", 32'(maxrun0), 32'd21);
        chk("b2b_count", 32'(wc0), 32'(wc_before + 16'd3));
        $display("back-to-back: run=%0d count=%0d", maxrun0, wc0);

        // select and in_data toggle while the word is in flight.
        send(0, 4'b0110, 1'b1, 7'b0111000);
        iv0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_data = 4'($urandom_range(0, 15));
            select  = ~select;
            tick();
        end
        wait_idle(0);
        chk("stable_cw", 32'(cw0), 32'h38);
        $display("stability: cw=%b", cw0);

        // Reset at bit 3, with a simultaneous word presented (must be dropped).
        wc_before = wc0;
        send(0, 4'hA, 1'b0, enc(4'hA, 1'b0));
        iv0 = 1'b0;
        for (int t = 0; t < 20 && q0.size() != 3; t++) tick();
        chk("reset_reached_bit3", 32'(q0.size()), 32'd3);
        rst = 1'b1;
        iv0 = 1'b1;
        in_data = 4'hF;
        q0.delete();
        tick();
        rst = 1'b0;
        iv0 = 1'b0;
        chk("midrst_txvalid", 32'(val0), 32'd0);
        chk("midrst_ready", 32'(rdy0), 32'd1);
        chk("midrst_count", 32'(wc0), 32'd0);
        chk("midrst_cw", 32'(cw0), 32'd0);
        tick();
        chk("midrst_no_word", 32'(val0), 32'd0);
        send(0, vecs[0].d, vecs[0].sel, vecs[0].cw);
        iv0 = 1'b0;
        wait_idle(0);
        chk("post_rst_cw", 32'(cw0), 32'(vecs[0].cw));
        chk("post_rst_count", 32'(wc0), 32'd1);
        $display("reset mid-word: count before=%0d after=%0d", wc_before, wc0);

        // word_count wrap.
        force dut0.word_count_reg = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut0.word_count_reg;
        tick();
        chk("wrap_preload", 32'(wc0), 32'hFFFF);
        send(0, 4'h9, 1'b1, enc(4'h9, 1'b1));
        iv0 = 1'b0;
        wait_idle(0);
        chk("wrap_count", 32'(wc0), 32'd0);
        $display("wrap: count=%0h", wc0);

        // GAP_CYCLES = 2: two queued words are 10 cycles apart.
        sofc2.delete();
        send(2, 4'h6, 1'b0, enc(4'h6, 1'b0));
        send(2, 4'hD, 1'b1, enc(4'hD, 1'b1));
        iv2 = 1'b0;
        wait_idle(2);
        chk("gap_sof_count", 32'(sofc2.size()), 32'd2);
        if (sofc2.size() == 2)
            chk("gap_spacing", 32'(sofc2[1] - sofc2[0]), 32'd10);
        chk("gap_word_count", 32'(wc2), 32'd2);
        chk("gap_cw", 32'(cw2), 32'(enc(4'hD, 1'b1)));
        $display("gap: words=%0d cw=%b", wc2, cw2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
